// File: rtl/motor_cmd_if.sv
// motor_cmd_if: valid/ready command channel carrying a direction and a target duty
interface motor_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [7:0] cmd_duty;
    modport master(output cmd_valid, cmd_dir, cmd_duty, input cmd_ready);
    modport slave(input cmd_valid, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: ramped PWM drive for two H-bridges with a dead interval before reversal
module motor_cmd_sequencer #(
    parameter int RAMP_DIV    = 4,
    parameter int RAMP_STEP   = 16,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    motor_cmd_if.slave  cmd,
    output logic [3:0]  motors,
    output logic [1:0]  cur_dir,
    output logic [7:0]  cur_duty,
    output logic        busy
);
    localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, RAMP_DOWN, DEAD} state_t;
    state_t state, nxt;
    logic [PW-1:0] pre;
    logic [DW-1:0] dead_cnt;
    logic [7:0] target, pend_duty, pwm_cnt, ramp, step;
    logic [1:0] pend_dir;
    logic [3:0] pat;
    logic pend_valid, accept, tick, is_stop, same, dead_done;
    assign step      = 8'(RAMP_STEP);
    assign accept    = cmd.cmd_valid & cmd.cmd_ready;
    assign tick      = pre == PW'(RAMP_DIV - 1);
    assign is_stop   = cmd.cmd_dir == 2'b00;
    assign same      = cmd.cmd_dir == cur_dir;
    assign dead_done = dead_cnt == DW'(DEAD_CYCLES - 1);
    // Step toward target, landing exactly on it when the remaining gap is within one step
    assign ramp = cur_duty < target ? (target - cur_duty > step ? cur_duty + step : target)
                                    : (cur_duty - target > step ? cur_duty - step : target);
    assign pat = cur_dir == 2'b01 ? 4'b1010 :
                 cur_dir == 2'b10 ? 4'b1001 :
                 cur_dir == 2'b11 ? 4'b0110 : 4'b0000;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (accept && !is_stop) nxt = RUN;
            RUN:       if (accept && !same) nxt = cur_duty != 8'd0 ? RAMP_DOWN : (is_stop ? IDLE : DEAD);
            RAMP_DOWN: if (cur_duty == 8'd0) nxt = pend_valid ? DEAD : IDLE;
            DEAD:      if (dead_done) nxt = RUN;
            default:   nxt = IDLE;
        endcase
    end
    always_comb begin
        cmd.cmd_ready = !reset && (state == IDLE || state == RUN);
        busy          = state == RAMP_DOWN || state == DEAD || cur_duty != target;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            pwm_cnt    <= '0;
            dead_cnt   <= '0;
            motors     <= '0;
            cur_dir    <= '0;
            cur_duty   <= '0;
            target     <= '0;
            pend_valid <= 1'b0;
            pend_dir   <= '0;
            pend_duty  <= '0;
        end else begin
            pre      <= tick ? '0 : pre + 1'b1;
            pwm_cnt  <= pwm_cnt + 1'b1;
            dead_cnt <= state == DEAD ? dead_cnt + 1'b1 : '0;
            motors   <= (state == IDLE || state == DEAD) ? 4'b0000 : pat & {4{pwm_cnt < cur_duty}};
            if (tick) cur_duty <= ramp;
            case (state)
                IDLE: if (accept && !is_stop) begin
                    cur_dir <= cmd.cmd_dir;
                    target  <= cmd.cmd_duty;
                end
                RUN: if (accept) begin
                    if (same) target <= cmd.cmd_duty;
                    else begin
                        target     <= '0;
                        pend_valid <= !is_stop;
                        pend_dir   <= cmd.cmd_dir;
                        pend_duty  <= cmd.cmd_duty;
                        if (is_stop && cur_duty == 8'd0) cur_dir <= '0;
                    end
                end
                RAMP_DOWN: if (cur_duty == 8'd0 && !pend_valid) cur_dir <= '0;
                DEAD: if (dead_done) begin
                    cur_dir    <= pend_dir;
                    target     <= pend_duty;
                    pend_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/motor_cmd_sequencer.md
MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 4: ramp tick period, in clk cycles (≥1).
REQ-002 SHALL have parameter RAMP_STEP, default 16: duty change per ramp tick (1..255).
REQ-003 SHALL have parameter DEAD_CYCLES, default 16: all-off interval before a direction reversal (≥1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid&cmd_ready at a clk edge.
REQ-008 SHALL have port cmd_dir, input, 2: requested direction; 00 stop, 01 forward, 10 right, 11 left.
REQ-009 SHALL have port cmd_duty, input, 8: target duty, 0..255.
REQ-010 SHALL have port motors, output, 4: {A_d, A_i, B_d, B_i} gated drive.
REQ-011 SHALL have port cur_dir, output, 2: applied direction.
REQ-012 SHALL have port cur_duty, output, 8: applied (ramped) duty.
REQ-013 SHALL have port busy, output, 1: high in RAMP_DOWN or DEAD, or when cur_duty != target duty.

Function
REQ-014 SHALL implement states IDLE, RUN, RAMP_DOWN, DEAD.
REQ-015 SHALL drive cmd_ready=1 in IDLE and RUN, 0 in RAMP_DOWN and DEAD, 0 while reset is high.
REQ-016 In IDLE, an accepted non-stop command SHALL load cur_dir=cmd_dir and target=cmd_duty, then enter RUN; an accepted stop SHALL be a no-op.
REQ-017 In RUN, an accepted command with cmd_dir==cur_dir SHALL update target only and stay in RUN.
REQ-018 In RUN, an accepted command with a different non-stop dir SHALL latch it (dir, duty) as pending and enter RAMP_DOWN, with target=0.
REQ-019 In RUN, an accepted stop SHALL set target=0 and enter RAMP_DOWN with no pending command.
REQ-020 In the RUN cases of REQ-018/019, if cur_duty==0 at acceptance, the FSM SHALL skip RAMP_DOWN: pending -> DEAD, stop -> IDLE.
REQ-021 RAMP_DOWN SHALL exit when cur_duty==0: to DEAD if pending, else to IDLE with cur_dir=00.
REQ-022 DEAD SHALL last exactly DEAD_CYCLES cycles with motors=0000.
REQ-023 On DEAD exit the FSM SHALL load cur_dir and target from pending and enter RUN.
REQ-024 A free-running prescaler SHALL count 0..RAMP_DIV-1 from reset; a tick occurs on its wrap.
REQ-025 On each tick cur_duty SHALL move toward target by RAMP_STEP, clamped to target, with no overshoot and no 8-bit wrap.
REQ-026 At an edge where a command is accepted and a tick occurs, the tick SHALL step toward the old target.
REQ-027 An 8-bit PWM counter SHALL free-run 0..255 and wrap to 0; pwm=(pwm_cnt<cur_duty), so duty 0 is never high and 255 is high 255 of 256 cycles.
REQ-028 Direction patterns SHALL be: stop 0000; forward A_d,B_d; right A_d,B_i; left A_i,B_d.
REQ-029 motors SHALL be registered = pattern(cur_dir) AND pwm, using pre-edge values (1-cycle latency), and forced 0000 in DEAD and IDLE.
REQ-030 A_d and A_i SHALL never be high together, nor B_d and B_i, in any cycle.
REQ-031 cmd_dir/cmd_duty SHALL be ignored when cmd_valid is low or cmd_ready is low.

Reset
REQ-032 With reset high at an edge: state=IDLE, cur_dir=00, cur_duty=0, target=0, pending cleared, prescaler=0, pwm_cnt=0, motors=0000, busy=0.
REQ-033 Reset mid-operation (any state) SHALL take effect at the next edge and discard any pending command.

Verification
REQ-034 Reset, then cmd fwd/64 -> RUN, cur_duty 16,32,48,64 on successive ticks (every 4 cycles); motors toggle 1010 with 64/256 duty; busy falls at 64.
REQ-035 RUN fwd/255 -> cur_duty ramps ..., 240, 255 (clamped, no wrap); motors high 255 of 256 cycles.
REQ-036 RUN fwd/64, then cmd right/128 -> cmd_ready=0; cur_duty ramps to 0; exactly 16 cycles of motors=0000; then cur_dir=10 and ramps to 128; A_i/B_d never asserted.
REQ-037 RUN left/32, cmd stop -> ramp to 0 -> IDLE with cur_dir=00, no DEAD interval, cmd_ready=1.
REQ-038 Reset asserted for 1 cycle during DEAD -> all outputs at reset values next edge; the pending right command never applies.
REQ-039 Command accepted on a tick edge in RUN fwd, cur_duty=32, target 64, new duty 16 -> cur_duty=48 at that edge, then 32, then 16.
